// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M execute unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU), valid/ready on both sides.
// Define FAST_MUL_EN to make multiplies single-cycle combinational; divides stay iterative.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    input  logic [2:0]      md_op,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] result_out,
    output logic            busy
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

    state_t          state, next_state;
    logic [CW-1:0]   count;
    logic [2:0]      op_q;
    logic            res_neg;
    logic            preset_q;
    logic [XLEN-1:0] acc_hi, acc_lo, opnd;

    logic            is_div, in1_signed, in2_signed, in1_neg, in2_neg;
    logic            div_by_zero, div_ovf, special, fast_mul, accept, neg_sel;
    logic [XLEN-1:0] in1_abs, in2_abs, special_result, fast_result;
    logic [XLEN:0]   mul_sum, div_shift;
    logic            div_ge;
    logic [XLEN-1:0] div_rem, fix_q, fix_r, fix_result;
    logic [2*XLEN-1:0] fix_prod;

    assign is_div      = md_op[2];
    assign in1_signed  = (md_op != 3'd3) && (md_op != 3'd5) && (md_op != 3'd7);
    assign in2_signed  = (md_op == 3'd0) || (md_op == 3'd1) || (md_op == 3'd4) || (md_op == 3'd6);
    assign in1_neg     = in1_signed && in1[XLEN-1];
    assign in2_neg     = in2_signed && in2[XLEN-1];
    assign in1_abs     = in1_neg ? -in1 : in1;
    assign in2_abs     = in2_neg ? -in2 : in2;
    assign div_by_zero = is_div && (in2 == '0);
    assign div_ovf     = is_div && !md_op[0] && (in1 == {1'b1, {(XLEN-1){1'b0}}}) && (in2 == '1);
    assign special     = div_by_zero || div_ovf;
    // Remainder follows the dividend's sign; quotient and product follow the operand sign mismatch.
    assign neg_sel     = (is_div && md_op[1]) ? in1_neg : (in1_neg ^ in2_neg);
    assign special_result = div_by_zero ? (md_op[1] ? in1 : '1) : (md_op[1] ? '0 : in1);

`ifdef FAST_MUL_EN
    logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
    assign fast_a      = {{XLEN{in1_neg}}, in1};
    assign fast_b      = {{XLEN{in2_neg}}, in2};
    assign fast_prod   = fast_a * fast_b;
    assign fast_mul    = !is_div;
    assign fast_result = (md_op == 3'd0) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`else
    assign fast_mul    = 1'b0;
    assign fast_result = '0;
`endif

    assign req_ready  = (state == IDLE) && !flush;
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state == DONE);
    assign busy       = (state != IDLE);

    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    assign div_shift = {acc_hi, acc_lo[XLEN-1]};
    assign div_ge    = (div_shift >= {1'b0, opnd});
    assign div_rem   = div_shift[XLEN-1:0] - opnd;
    assign fix_prod  = res_neg ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    assign fix_q     = res_neg ? -acc_lo : acc_lo;
    assign fix_r     = res_neg ? -acc_hi : acc_hi;

    // Preset results (special divides, fast multiplies) are parked in acc_lo and pass through FIX unchanged.
    always_comb begin
        fix_result = fix_q;
        if (preset_q) begin
            fix_result = acc_lo;
        end else begin
            case (op_q)
                3'd0:       fix_result = fix_prod[XLEN-1:0];
                3'd1, 3'd2,
                3'd3:       fix_result = fix_prod[2*XLEN-1:XLEN];
                3'd6, 3'd7: fix_result = fix_r;
                default:    fix_result = fix_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept) next_state = (special || fast_mul) ? FIX : ITER;
            ITER: if (count == CW'(XLEN - 1)) next_state = FIX;
            FIX:  next_state = DONE;
            DONE: if (resp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (flush) next_state = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count      <= '0;
            op_q       <= '0;
            res_neg    <= 1'b0;
            preset_q   <= 1'b0;
            acc_hi     <= '0;
            acc_lo     <= '0;
            opnd       <= '0;
            result_out <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_q     <= md_op;
                    res_neg  <= neg_sel;
                    preset_q <= special || fast_mul;
                    count    <= '0;
                    acc_hi   <= '0;
                    opnd     <= is_div ? in2_abs : in1_abs;
                    if (special)       acc_lo <= special_result;
                    else if (fast_mul) acc_lo <= fast_result;
                    else               acc_lo <= is_div ? in1_abs : in2_abs;
                end
                ITER: begin
                    count <= count + 1'b1;
                    if (op_q[2]) begin
                        acc_hi <= div_ge ? div_rem : div_shift[XLEN-1:0];
                        acc_lo <= {acc_lo[XLEN-2:0], div_ge};
                    end else begin
                        {acc_hi, acc_lo} <= {mul_sum, acc_lo[XLEN-1:1]};
                    end
                end
                FIX: result_out <= fix_result;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against an arithmetic reference model.
// Honours FAST_MUL_EN for the expected multiply latency.
module tb_muldiv_unit;
    localparam int XLEN = 32;
`ifdef FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, flush, req_valid, req_ready, resp_valid, resp_ready, busy;
    logic [31:0] in1, in2, result_out;
    logic [2:0]  md_op;
    int          checks = 0;
    int          errors = 0;

    // -2001 * -2001 = 4004001 = 0x003D18A1
    vec_t dir_vecs [15] = '{
        '{3'd0, 32'd26,        32'd13,        32'd338},
        '{3'd1, 32'hFFFFF82F,  32'hFFFFF82F,  32'h00000000},
        '{3'd0, 32'hFFFFF82F,  32'hFFFFF82F,  32'h003D18A1},
        '{3'd2, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFF},
        '{3'd3, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE},
        '{3'd2, 32'd2,         32'h80000000,  32'h00000001},
        '{3'd4, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD},
        '{3'd6, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF},
        '{3'd5, 32'd26,        32'd0,         32'hFFFFFFFF},
        '{3'd7, 32'd26,        32'd0,         32'd26},
        '{3'd4, 32'd5,         32'd0,         32'hFFFFFFFF},
        '{3'd6, 32'hFFFFFFF0,  32'd0,         32'hFFFFFFF0},
        '{3'd4, 32'h80000000,  32'hFFFFFFFF,  32'h80000000},
        '{3'd6, 32'h80000000,  32'hFFFFFFFF,  32'h00000000},
        '{3'd7, 32'd100,       32'd7,         32'd2}
    };

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .in1        (in1),
        .in2        (in2),
        .md_op      (md_op),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .result_out (result_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'd0, b});
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFFFFFF; p = sa / sb; return p[31:0]; end
            3'd5: begin if (b == 0) return 32'hFFFFFFFF; return a / b; end
            3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            default: begin if (b == 0) return a; return a % b; end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && (b == 0)) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
        if (!op[2] && FAST) return 1;
        return XLEN + 1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int guard = 0;
        while (!req_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("req_ready_before_issue", 32'(req_ready), 32'd1);
        md_op     = op;
        in1       = a;
        in2       = b;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        in1       = $urandom;
        in2       = $urandom;
        md_op     = 3'($urandom_range(0, 7));
    endtask

    task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit rr_early);
        int lat = 0;
        applyStimulus(op, a, b);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
        while (!resp_valid && lat < 100) begin
            resp_ready = rr_early ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        resp_ready = 1'b0;
        checkOutput({tag, "_latency"}, 32'(lat), 32'(ref_latency(op, a, b)));
        checkOutput({tag, "_result"}, result_out, exp);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        checkOutput({tag, "_resp_drop"}, 32'(resp_valid), 32'd0);
        checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        int          lat, seen;

        reset = 1'b1; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        in1 = '0; in2 = '0; md_op = '0;
        @(posedge clk); #1;
        checkOutput("reset_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("reset_result", result_out, 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
        reset = 1'b0;
        @(posedge clk); #1;

        foreach (dir_vecs[i]) begin
            runOp($sformatf("dir%0d", i), dir_vecs[i].op, dir_vecs[i].a, dir_vecs[i].b, dir_vecs[i].exp, 1'b0);
        end

        // Back-pressure: result must hold and no new request accepted while the consumer stalls.
        applyStimulus(3'd0, 32'd26, 32'd13);
        lat = 0;
        while (!resp_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            checkOutput("hold_result", result_out, 32'd338);
            checkOutput("hold_req_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        checkOutput("hold_release", 32'(resp_valid), 32'd0);

        applyStimulus(3'd4, 32'd1000, 32'd7);
        repeat (5) @(posedge clk);
        #1 flush = 1'b1;
        #1 checkOutput("flush_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        checkOutput("flush_busy", 32'(busy), 32'd0);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (resp_valid) seen++;
            @(posedge clk); #1;
        end
        checkOutput("flush_no_resp", 32'(seen), 32'd0);

        md_op = 3'd0; in1 = 32'd3; in2 = 32'd4;
        req_valid = 1'b1; flush = 1'b1;
        #1 checkOutput("flush_blocks_req", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0;
        checkOutput("flush_req_not_taken", 32'(busy), 32'd0);

        runOp("pre_reset", 3'd5, 32'd99, 32'd4, 32'd24, 1'b0);
        applyStimulus(3'd4, 32'd12345, 32'd17);
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("midreset_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_result", result_out, 32'd0);
        checkOutput("midreset_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: a = 32'($urandom_range(0, 300));
                default: ;
            endcase
            runOp($sformatf("rnd%0d_op%0d", i, op), op, a, b, ref_result(op, a, b), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
